parity_word_shifter: RTL
========================

Name: parity_word_shifter

Overview:
- Downstream stage of the 7-bit parity generator: accepts its 8-bit coded word (data[6:0] in bits 7:1, parity in bit 0) plus the parity-mode bit, and serialises it onto a single line.
- Frame format: start bit (0), WIDTH word bits, stop bit (1). Line idles high.
- Valid/ready handshake on input; busy/done status for the surrounding test bench and system.

Parameters:
- WIDTH, 8, coded word width in bits (7 data + 1 parity).
- BIT_CYCLES, 1, clock cycles each serial bit is held (>=1).
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first, 0 = bit 0 first.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream word available.
- in_ready  out  1  block can accept a word this cycle.
- in_word  in  WIDTH  coded word from the parity stage.
- in_mode  in  1  parity mode used upstream (0 = even, 1 = odd).
- ser_out  out  1  serial line.
- busy  out  1  high while a frame is on the line.
- done  out  1  one-cycle pulse in the last cycle of the stop bit.
- parity_err  out  1  parity mismatch flag (see Optional Feature).

Behaviour:
- Reset applies at a clk edge with rst_n=0. After that edge: state=IDLE, ser_out=1, busy=0, done=0, parity_err=0, in_ready=1 (ready = state==IDLE).
- Accept: rising edge with state==IDLE and in_valid=1 and rst_n=1. At that edge, capture in_word into the shift register and load bit counter = WIDTH and cycle counter = BIT_CYCLES-1.
- FSM: IDLE -> START -> SHIFT -> STOP -> IDLE. All outputs are registered.
  - START: ser_out=0 for BIT_CYCLES cycles.
  - SHIFT: WIDTH bits, each held BIT_CYCLES cycles, in the order set by MSB_FIRST. Shift on the last cycle of each bit. Leave SHIFT when the bit counter reaches 0.
  - STOP: ser_out=1 for BIT_CYCLES cycles. done=1 only in the final STOP cycle. Next state is IDLE.
- busy=1 in START, SHIFT and STOP. in_ready=0 in the same states; in_valid is ignored while busy.
- Timing with accept at edge E0: the frame occupies cycles 1..(WIDTH+2)*BIT_CYCLES after E0. The next accept is possible at the end of the following IDLE cycle. Start-to-start minimum is (WIDTH+2)*BIT_CYCLES+1 cycles.
- in_word and in_mode may change freely after accept; only the captured copy is used.
- Reset mid-frame: abort at the edge. ser_out=1 and state=IDLE immediately; no done pulse; the captured word is discarded.
- Counters: bit counter is clog2(WIDTH+1) bits; cycle counter is clog2(BIT_CYCLES) bits (minimum 1). Neither wraps: each reloads on entry to a new bit.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - On accept, compute r = XOR of all bits of in_word, and register parity_err <= (r != in_mode).
  - The flag holds until the next accept or reset.
  - The word is still transmitted unchanged.
- Not defined: parity_err is tied to 0 and no XOR logic is built.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> ser_out=1, busy=0, done=0, in_ready=1 after the first reset edge.
- Defaults: in_word=8'b1011_0010, in_mode=0, in_valid pulsed one cycle -> ser_out over cycles 1..10 = 0,1,0,1,1,0,0,1,0,1. busy=1 for cycles 1..10; done only in cycle 10; parity_err=0.
- in_valid held high with two words 8'hB2 and 8'h02 -> second start bit begins 11 cycles after the first start bit; in_ready=0 during cycles 1..10.
- BIT_CYCLES=3, MSB_FIRST=0, in_word=8'h02 -> frame lasts 30 cycles. Each bit held 3 cycles; the LSB (0) follows the start bit, then 1; done in cycle 30.
- rst_n=0 at cycle 5 of a frame -> ser_out=1, busy=0 after that edge; no done pulse; in_ready=1 next cycle.
- With PARITY_CHECK_EN:
  - in_word=8'h01, in_mode=0 -> parity_err=1 from the cycle after accept.
  - Next accept with in_word=8'h01, in_mode=1 -> parity_err clears to 0.
  - Without the macro, parity_err stays 0 throughout.

Source files
------------

// File: rtl/parity_word_shifter.sv
// rtl/parity_word_shifter.sv - frames a parity-coded word as start/data/stop on one serial line (optional PARITY_CHECK_EN)
module parity_word_shifter #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_mode,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             parity_err
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic             head_now;
  logic             head_next;
  logic             accept;

  assign accept = (state == IDLE) && in_valid;

  // Shift direction and the bit that goes on the line now / after the next shift
  always_comb begin
    shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    head_now   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    head_next  = MSB_FIRST ? shreg_next[WIDTH-1] : shreg_next[0];
  end

  // Frame sequencer: every line/status output is registered here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      ser_out  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state    <= START;
            shreg    <= in_word;
            bit_cnt  <= BIT_LOAD;
            cyc_cnt  <= CYC_LAST;
            ser_out  <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        START: begin
          if (cyc_cnt == '0) begin
            state   <= SHIFT;
            cyc_cnt <= CYC_LAST;
            ser_out <= head_now;
          end else begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end
        end
        SHIFT: begin
          if (cyc_cnt == '0) begin
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt - BW'(1);
            cyc_cnt <= CYC_LAST;
            if (bit_cnt == BW'(1)) begin
              state   <= STOP;
              ser_out <= 1'b1;
              // a one-cycle stop bit is also its own final cycle
              done    <= (BIT_CYCLES == 1);
            end else begin
              ser_out <= head_next;
            end
          end else begin
            cyc_cnt <= cyc_cnt - CW'(1);
          end
        end
        STOP: begin
          if (cyc_cnt == '0) begin
            state    <= IDLE;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt - CW'(1);
            done    <= (cyc_cnt == CW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity verdict is taken on the accepted word and held until the next accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept) begin
      parity_err <= ((^in_word) != in_mode);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = in_mode;
  assign parity_err  = 1'b0;
`endif

endmodule
